// File: rtl/nn_pkg.sv
// Shared types and widths for the neuron datapath.
// Multiply-accumulate state encoding and operand/product/result widths.
package nn_pkg;

  localparam int unsigned OPER_W = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One (activation, weight) operand pair as presented on the input port.
  typedef struct packed {
    logic [OPER_W-1:0] x;
    logic [OPER_W-1:0] w;
  } pair_t;

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational unsigned 4x4 -> 8 bit multiplier.
// Shared arithmetic primitive used by the neuron MAC stage.
module multiplier_4bit
  import nn_pkg::*;
(
  input  logic [OPER_W-1:0] a,
  input  logic [OPER_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/neuron_mac_accumulator.sv
// One neuron's multiply-accumulate stage: streams NUM_INPUTS (x, w) pairs,
// sums their products and emits a shifted, saturated result plus a fire bit.
module neuron_mac_accumulator
  import nn_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned THRESHOLD  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPER_W-1:0] in_x,
  input  logic [OPER_W-1:0] in_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_fire,
  output logic              busy
);

  localparam int unsigned ACC_W = PROD_W + $clog2(NUM_INPUTS);
  localparam int unsigned CNT_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] prod;
  logic              prod_vld;
  logic [ACC_W-1:0]  acc;

  pair_t             pair_c;
  logic [PROD_W-1:0] prod_c;
  logic              xfer_c;
  logic              hs_c;
  logic              last_c;
  logic [ACC_W-1:0]  acc_sum_c;
  logic [ACC_W-1:0]  shifted_c;
  logic [OUT_W-1:0]  sat_c;
  logic              fire_c;

  assign pair_c = '{x: in_x, w: in_w};

  multiplier_4bit u_mult (
    .a (pair_c.x),
    .b (pair_c.w),
    .p (prod_c)
  );

  assign xfer_c = in_valid & in_ready;
  assign hs_c   = out_valid & out_ready;
  assign last_c = xfer_c && (cnt == CNT_LAST);

  // Stage 2 sum including the registered product still in flight.
  assign acc_sum_c = prod_vld ? (acc + ACC_W'(prod)) : acc;
  assign shifted_c = acc_sum_c >> SHIFT;
  assign sat_c     = (|shifted_c[ACC_W-1:OUT_W]) ? '1 : shifted_c[OUT_W-1:0];
  assign fire_c    = 32'(acc_sum_c) >= THRESHOLD;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_c) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (hs_c) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      in_ready  <= 1'b1;
      cnt       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_fire  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == ACCUM);

      prod_vld <= xfer_c;
      if (xfer_c) prod <= prod_c;

      if (last_c)      cnt <= '0;
      else if (xfer_c) cnt <= cnt + CNT_W'(1);

      if (hs_c) acc <= '0;
      else      acc <= acc_sum_c;

      // Result is captured as the final product lands, so it is valid on entry to DONE.
      if (state == DRAIN) begin
        out_valid <= 1'b1;
        out_data  <= sat_c;
        out_fire  <= fire_c;
      end else if (hs_c) begin
        out_valid <= 1'b0;
      end

      if (hs_c)        busy <= 1'b0;
      else if (xfer_c) busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Bench for neuron_mac_accumulator: two instances (SHIFT=0 and SHIFT=2) share
// stimulus; results are checked against a per-frame arithmetic reference.
module tb_neuron_mac_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_x;
  logic [3:0] in_w;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_fire0, busy0;
  logic [7:0] out_data0;
  logic       in_ready2, out_valid2, out_fire2, busy2;
  logic [7:0] out_data2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  neuron_mac_accumulator #(.NUM_INPUTS(4), .SHIFT(0), .THRESHOLD(128)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_x(in_x), .in_w(in_w), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_fire(out_fire0), .busy(busy0)
  );

  neuron_mac_accumulator #(.NUM_INPUTS(4), .SHIFT(2), .THRESHOLD(128)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_x(in_x), .in_w(in_w), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_fire(out_fire2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sat(input int sum, input int sh);
    int v;
    v = sum >> sh;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair (after an optional idle gap) and advance past its transfer edge.
  task automatic send_pair(input int x, input int w, input int gap);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) tick();
    end
    in_x     = 4'(x);
    in_w     = 4'(w);
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !in_ready0; i++) tick();
    chk("in_ready_wait", 32'(in_ready0), 32'd1);
    tick();
  endtask

  // Wait for the result, stall it while throwing ignored input pulses, then accept.
  task automatic get_result(input int delay, input int sum, input string tag);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid0; i++) tick();
    chk({tag, "_valid"}, 32'(out_valid0), 32'd1);
    repeat (delay) begin
      in_valid = 1'($urandom_range(0, 1));
      in_x     = 4'($urandom);
      in_w     = 4'($urandom);
      tick();
    end
    chk({tag, "_data0"}, 32'(out_data0), sat(sum, 0));
    chk({tag, "_fire0"}, 32'(out_fire0), (sum >= 128) ? 1 : 0);
    chk({tag, "_data2"}, 32'(out_data2), sat(sum, 2));
    chk({tag, "_fire2"}, 32'(out_fire2), (sum >= 128) ? 1 : 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_hs_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "_hs_ready"}, 32'(in_ready0), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready0),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "_out_data"},  32'(out_data0),  32'd0);
    chk({tag, "_out_fire"},  32'(out_fire0),  32'd0);
    chk({tag, "_busy"},      32'(busy0),      32'd0);
    chk({tag, "_in_ready2"}, 32'(in_ready2),  32'd1);
    chk({tag, "_out_valid2"},32'(out_valid2), 32'd0);
    chk({tag, "_busy2"},     32'(busy2),      32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[4];
    int ws[4];
    int sum;
    int x;
    int w;
    int gap;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Back-to-back frame with exact latency.
    xs = '{6, 10, 11, 7};
    ws = '{9, 3, 5, 12};
    for (int k = 0; k < 4; k++) begin
      send_pair(xs[k], ws[k], 0);
      if (k == 0) chk("t1_busy", 32'(busy0), 32'd1);
    end
    in_valid = 1'b0;
    chk("t1_drain_valid", 32'(out_valid0), 32'd0);
    chk("t1_drain_ready", 32'(in_ready0), 32'd0);
    tick();
    chk("t1_latency_valid", 32'(out_valid0), 32'd1);
    get_result(0, 223, "t1");
    chk("t1_busy_after", 32'(busy0), 32'd0);

    // Saturation on SHIFT=0, no saturation on SHIFT=2.
    for (int k = 0; k < 4; k++) send_pair(15, 15, 0);
    get_result(0, 900, "t2");

    // Gapped input: count only advances on transfers.
    xs = '{1, 0, 3, 2};
    ws = '{2, 15, 3, 5};
    for (int k = 0; k < 4; k++) begin
      send_pair(xs[k], ws[k], 1 + (k % 3));
      if (k == 2) begin
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t3_no_early_valid", 32'(out_valid0), 32'd0);
        chk("t3_busy", 32'(busy0), 32'd1);
      end
    end
    get_result(1, 21, "t3");

    // Stalled result stays stable, stray inputs ignored, next frame starts from 0.
    for (int k = 0; k < 4; k++) send_pair(1, 1, 0);
    in_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'(c % 2);
      in_x = 4'd15;
      in_w = 4'd15;
      tick();
      chk("t4_stall_valid", 32'(out_valid0), 32'd1);
      chk("t4_stall_data", 32'(out_data0), 32'd4);
      chk("t4_stall_ready", 32'(in_ready0), 32'd0);
    end
    get_result(0, 4, "t4");
    for (int k = 0; k < 4; k++) send_pair(2, 3, 0);
    get_result(0, 24, "t4_next");

    // Reset mid-frame.
    send_pair(6, 9, 0);
    send_pair(6, 9, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_state("t5_reset");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send_pair(6, 9, 0);
    get_result(0, 216, "t5");

    // Random frames with input gaps and output back-pressure.
    for (int f = 0; f < 1000; f++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        x = int'($urandom_range(0, 15));
        w = int'($urandom_range(0, 15));
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        send_pair(x, w, gap);
        sum += x * w;
      end
      get_result(int'($urandom_range(0, 3)), sum, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
